// File: rtl/l2_cache_pkg.sv
// Shared definitions for the L2 tag/state block: fill FSM encoding and default geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l2_cache_pkg;

    localparam int TAG_BITS   = 12;
    localparam int INDEX_BITS = 4;
    localparam int WAYS       = 4;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EVICT,
        WRITE,
        DONE
    } fillState_t;

endpackage

// File: rtl/lru_age_update.sv
// Age-based LRU update for one set: touched way becomes age 0, younger ways age by one.
// Latency: combinational.
// Backpressure: none.
// Ports: agesIn/agesOut hold way w's age in bits [w*wayBits +: wayBits]; touchWay is the way being used.
module lru_age_update #(
    parameter int ways    = 4,
    parameter int wayBits = $clog2(ways)
) (
    input  logic [ways*wayBits-1:0] agesIn,
    input  logic [wayBits-1:0]      touchWay,
    output logic [ways*wayBits-1:0] agesOut
);

    logic [wayBits-1:0] touchedAge;

    always_comb begin
        touchedAge = '0;
        for (int w = 0; w < ways; w++) begin
            if (touchWay == wayBits'(w)) begin
                touchedAge = agesIn[w*wayBits +: wayBits];
            end
        end

        // Only ways younger than the touched one shift, which keeps the ages a permutation.
        agesOut = agesIn;
        for (int w = 0; w < ways; w++) begin
            if (touchWay == wayBits'(w)) begin
                agesOut[w*wayBits +: wayBits] = '0;
            end else if (agesIn[w*wayBits +: wayBits] < touchedAge) begin
                agesOut[w*wayBits +: wayBits] = agesIn[w*wayBits +: wayBits] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_tag_writer.sv
// L2 tag/valid/dirty/LRU owner: lookup read port, hit touches, and miss-fill install with victim writeback.
// Latency: fill accepted at edge k -> fillDone in cycle k+3, plus one cycle per EVICT cycle.
// Backpressure: fillReady only in IDLE; EVICT holds evictValid/evictTag/evictIndex stable until evictReady.
// Ports: clk/reset (sync, active-high); lookupIndex -> lookupTags/lookupValid (combinational);
//        hitValid/hitIndex/hitWay/hitWrite touch; fillValid/fillReady/fillTag/fillIndex/fillDirty request;
//        evictValid/evictReady/evictTag/evictIndex writeback; fillDone/fillWay completion.
module l2_tag_writer
    import l2_cache_pkg::*;
#(
    parameter int tagBits   = TAG_BITS,
    parameter int indexBits = INDEX_BITS,
    parameter int ways      = WAYS,
    localparam int wayBits  = $clog2(ways)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [indexBits-1:0]    lookupIndex,
    output logic [ways*tagBits-1:0] lookupTags,
    output logic [ways-1:0]         lookupValid,
    input  logic                    hitValid,
    input  logic [indexBits-1:0]    hitIndex,
    input  logic [wayBits-1:0]      hitWay,
    input  logic                    hitWrite,
    input  logic                    fillValid,
    output logic                    fillReady,
    input  logic [tagBits-1:0]      fillTag,
    input  logic [indexBits-1:0]    fillIndex,
    input  logic                    fillDirty,
    output logic                    evictValid,
    input  logic                    evictReady,
    output logic [tagBits-1:0]      evictTag,
    output logic [indexBits-1:0]    evictIndex,
    output logic                    fillDone,
    output logic [wayBits-1:0]      fillWay
);

    localparam int sets = 2**indexBits;

    logic [tagBits-1:0]      tagMem   [sets][ways];
    logic [ways-1:0]         validMem [sets];
    logic [ways-1:0]         dirtyMem [sets];
    logic [ways*wayBits-1:0] ageMem   [sets];

    fillState_t state, stateNext;

    logic [tagBits-1:0]   fillTagQ;
    logic [indexBits-1:0] fillIdxQ;
    logic                 fillDirtyQ;
    logic [wayBits-1:0]   victimQ;
    logic [tagBits-1:0]   victimTagQ;

    logic [wayBits-1:0]      victimSel;
    logic [wayBits-1:0]      lruWay;
    logic                    anyInvalid;
    logic                    victimEvict;
    logic [ways*wayBits-1:0] hitAges;
    logic [ways*wayBits-1:0] fillAges;
    logic                    hitCollide;
    logic                    hitApply;
    logic                    collideDirty;

    lru_age_update #(.ways(ways), .wayBits(wayBits)) hitLru (
        .agesIn   (ageMem[hitIndex]),
        .touchWay (hitWay),
        .agesOut  (hitAges)
    );

    lru_age_update #(.ways(ways), .wayBits(wayBits)) fillLru (
        .agesIn   (ageMem[fillIdxQ]),
        .touchWay (victimQ),
        .agesOut  (fillAges)
    );

    always_comb begin
        lookupTags = '0;
        for (int w = 0; w < ways; w++) begin
            lookupTags[w*tagBits +: tagBits] = tagMem[lookupIndex][w];
        end
    end

    assign lookupValid = validMem[lookupIndex];

    // Victim choice: lowest invalid way if any, else the way holding the oldest age.
    always_comb begin
        victimSel  = '0;
        lruWay     = '0;
        anyInvalid = 1'b0;
        for (int w = ways-1; w >= 0; w--) begin
            if (!validMem[fillIdxQ][w]) begin
                victimSel  = wayBits'(w);
                anyInvalid = 1'b1;
            end
        end
        for (int w = 0; w < ways; w++) begin
            if (ageMem[fillIdxQ][w*wayBits +: wayBits] == wayBits'(ways-1)) begin
                lruWay = wayBits'(w);
            end
        end
        if (!anyInvalid) begin
            victimSel = lruWay;
        end
        victimEvict = !anyInvalid && dirtyMem[fillIdxQ][lruWay];
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fillValid) stateNext = SELECT;
            SELECT:  stateNext = victimEvict ? EVICT : WRITE;
            EVICT:   if (evictReady) stateNext = WRITE;
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign fillReady  = (state == IDLE);
    assign evictValid = (state == EVICT);
    assign fillDone   = (state == DONE);
    assign evictTag   = evictValid ? victimTagQ : '0;
    assign evictIndex = evictValid ? fillIdxQ : '0;
    assign fillWay    = fillDone ? victimQ : '0;

    // A hit on the set being written in WRITE loses to the fill; only its dirty mark survives.
    assign hitCollide   = (state == WRITE) && (hitIndex == fillIdxQ);
    assign hitApply     = hitValid && validMem[hitIndex][hitWay] && !hitCollide;
    assign collideDirty = hitValid && hitCollide && hitWrite && (hitWay == victimQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fillTagQ   <= '0;
            fillIdxQ   <= '0;
            fillDirtyQ <= 1'b0;
            victimQ    <= '0;
            victimTagQ <= '0;
            for (int s = 0; s < sets; s++) begin
                validMem[s] <= '0;
                dirtyMem[s] <= '0;
                for (int w = 0; w < ways; w++) begin
                    tagMem[s][w]                     <= '0;
                    ageMem[s][w*wayBits +: wayBits] <= wayBits'(w);
                end
            end
        end else begin
            state <= stateNext;

            if (fillValid && fillReady) begin
                fillTagQ   <= fillTag;
                fillIdxQ   <= fillIndex;
                fillDirtyQ <= fillDirty;
            end

            if (state == SELECT) begin
                victimQ    <= victimSel;
                victimTagQ <= tagMem[fillIdxQ][victimSel];
            end

            if (hitApply) begin
                ageMem[hitIndex] <= hitAges;
                if (hitWrite) begin
                    dirtyMem[hitIndex][hitWay] <= 1'b1;
                end
            end

            if (state == WRITE) begin
                tagMem[fillIdxQ][victimQ]   <= fillTagQ;
                validMem[fillIdxQ][victimQ] <= 1'b1;
                dirtyMem[fillIdxQ][victimQ] <= fillDirtyQ | collideDirty;
                ageMem[fillIdxQ]            <= fillAges;
            end
        end
    end

endmodule

// File: doc/l2_tag_writer.md
Name: l2_tag_writer

Overview:
- Owns the L2 tag/valid/dirty/LRU state for every set.
- Presents a set's stored tags to the per-way tag comparators through a combinational read port.
- Installs new tags on a miss fill: picks a victim way, issues a writeback handshake when the victim is dirty, writes the tag, then updates LRU.
- Accepts hit "touch" updates from the lookup path so that LRU and dirty state stay current.

Parameters:
- tagBits, 12, width of one stored tag; matches the comparator tag width.
- indexBits, 4, set index width; sets = 2**indexBits.
- ways, 4, associativity; power of two and at least 2; wayBits = $clog2(ways).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- lookupIndex  in  indexBits  set to present to the comparators.
- lookupTags  out  ways*tagBits  stored tags of lookupIndex; way w occupies bits [w*tagBits +: tagBits]; combinational.
- lookupValid  out  ways  valid bits of lookupIndex; combinational.
- hitValid  in  1  one-cycle touch for a hit.
- hitIndex  in  indexBits  set of the hit.
- hitWay  in  wayBits  way of the hit.
- hitWrite  in  1  the hit was a write; sets the dirty bit.
- fillValid  in  1  miss fill request.
- fillReady  out  1  high only in IDLE.
- fillTag  in  tagBits  tag to install.
- fillIndex  in  indexBits  set to fill.
- fillDirty  in  1  installed line starts dirty (write-allocate).
- evictValid  out  1  dirty victim writeback request.
- evictReady  in  1  downstream accepts the writeback.
- evictTag  out  tagBits  victim tag.
- evictIndex  out  indexBits  victim set.
- fillDone  out  1  one-cycle completion pulse.
- fillWay  out  wayBits  way written; valid while fillDone is high.

Behaviour:
- Reset (synchronous, active-high):
  - All valid and dirty bits are cleared, and all tags are set to 0.
  - The LRU age of way w in every set is set to w, so way ways-1 is the LRU way.
  - State returns to IDLE; fillDone, evictValid, evictTag, evictIndex and fillWay are all 0.
  - Reset asserted mid-fill abandons the fill: no tag write and no further evictValid.
- Request handshake: a request is accepted on an edge where fillValid && fillReady. fillTag, fillIndex and fillDirty are latched at that edge.
- FSM:
  - IDLE: on accept, go to SELECT.
  - SELECT (1 cycle): choose the victim.
    - If any way is invalid, the victim is the lowest-numbered invalid way.
    - Otherwise the victim is the way whose age equals ways-1.
    - The victim way, its tag and its dirty bit are latched here; later touches do not change the victim.
    - If the victim is valid and dirty, go to EVICT; otherwise go to WRITE.
  - EVICT: evictValid=1, with evictTag and evictIndex stable. Stay until evictReady=1, then go to WRITE. evictValid deasserts on the cycle after the handshake.
  - WRITE (1 cycle): at the end of the cycle, write tag[victim]=fillTag, valid=1, dirty=fillDirty, and apply an LRU touch of the victim. Go to DONE.
  - DONE (1 cycle): fillDone=1 and fillWay=victim. Go to IDLE.
- Latency: with no eviction, accept at edge k gives fillDone high in cycle k+3, and fillReady high again in cycle k+4. Each eviction wait cycle adds one cycle.
- LRU touch of way w:
  - Every way with age < age[w] increments by one; age[w] becomes 0.
  - Ages remain a permutation of 0..ways-1 at all times.
- Hit touch:
  - Applied at the edge where hitValid=1, in any state.
  - hitWrite=1 also sets dirty[hitIndex][hitWay].
  - A hit to an invalid way is ignored, with no state change.
- Collision: hitValid in the WRITE cycle with hitIndex==latched fillIndex drops the hit touch; the fill update wins. If additionally hitWay==victim and hitWrite=1, the dirty bit is ORed in.
- lookupTags and lookupValid reflect state after the last edge; a write is visible the cycle after WRITE.

Decomposition:
- Package l2_cache_pkg:
  - Fill FSM state enum {IDLE, SELECT, EVICT, WRITE, DONE}.
  - Default constants TAG_BITS, INDEX_BITS, WAYS.
- Sub-module lru_age_update (combinational): takes the current ages of one set and the touched way, returns the new ages. It is shared by the hit touch and fill paths.

Test Plan:
1. Empty set fill: after reset, fill tag 0x0AB, index 3 -> fillDone in cycle k+3 with fillWay=0; lookupIndex=3 then shows way0 tag 0x0AB, lookupValid=4'b0001; evictValid never asserts.
2. Fill ways then LRU: fill tags 0x001..0x004 into index 5, then touch way1 with a hit, then fill 0x005 -> victim is way0, the oldest untouched way; with clean lines, evictValid stays 0.
3. Dirty eviction backpressure: set 5 full with way0 dirty; fill 0x006 with evictReady held low for 3 cycles -> evictValid=1, evictTag=0x001, evictIndex=5 held stable for 4 cycles; fillDone follows 2 cycles after the handshake.
4. Hit-write dirtying: hitWrite on index 2 way 3, then force that way to be LRU and fill -> eviction issued for way 3's tag.
5. Collision: hitValid on the fill's index during WRITE -> fill's LRU result kept (victim age 0); the hit's age change is absent.
6. Reset mid-EVICT: assert reset while evictValid=1 -> next cycle evictValid=0, fillReady=1, and all lookupValid=0.
